// File: rtl/mult_pkg.sv
// Shared types and helpers for the signed multiplier family.
package mult_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CW    = $clog2(DEF_WIDTH);
  localparam int MAXW      = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } state_t;

  // Two's-complement negate at the widest supported width; callers size-cast the result.
  function automatic logic [MAXW-1:0] twos_neg(input logic [MAXW-1:0] x);
    return ~x + MAXW'(1);
  endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add partial-sum step of the sign-magnitude multiplier.
module mult_step
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2*WIDTH-1:0] partsum,
  input  logic [WIDTH-1:0]   magb,
  input  logic               mbit,
  output logic [2*WIDTH-1:0] nxt
);

  assign nxt = (partsum << 1) + (mbit ? {{WIDTH{1'b0}}, magb} : '0);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential signed multiplier: one partial-sum step per clock, MSB of |A| first.
//   state | meaning
//   IDLE  | waiting for start, result held
//   RUN   | WIDTH shift-add steps over magA bits
//   SIGN  | apply product sign, pulse done
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

  localparam int CW = $clog2(WIDTH);

  state_t             state, state_nxt;
  logic               sign;
  logic [WIDTH-1:0]   maga, magb;
  logic [2*WIDTH-1:0] partsum, partsum_nxt;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] signed_sum;

  assign abs_a      = A[WIDTH-1] ? WIDTH'(twos_neg(MAXW'(A))) : A;
  assign abs_b      = B[WIDTH-1] ? WIDTH'(twos_neg(MAXW'(B))) : B;
  assign signed_sum = sign ? (2*WIDTH)'(twos_neg(MAXW'(partsum))) : partsum;
  assign busy       = (state != IDLE);

  mult_step #(.WIDTH(WIDTH)) u_step (
    .partsum (partsum),
    .magb    (magb),
    .mbit    (maga[count]),
    .nxt     (partsum_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (count == '0) state_nxt = SIGN;
      SIGN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign    <= 1'b0;
      maga    <= '0;
      magb    <= '0;
      partsum <= '0;
      count   <= '0;
      done    <= 1'b0;
      out     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign    <= A[WIDTH-1] ^ B[WIDTH-1];
            maga    <= abs_a;
            magb    <= abs_b;
            partsum <= '0;
            count   <= CW'(WIDTH-1);
          end
        end
        RUN: begin
          partsum <= partsum_nxt;
          if (count != '0) count <= count - 1'b1;
        end
        SIGN: begin
          out  <= signed_sum;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed and randomized checks of mult_seq_ctrl against hand-computed products.
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic        busy, done;
  logic [15:0] out_w;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .busy  (busy),
    .done  (done),
    .out   (out_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Pulse start, scramble operands after acceptance, wait for done with a bound.
  task automatic do_op(input logic [7:0] opa, input logic [7:0] opb,
                       input logic [15:0] exp, input string tag);
    int n;
    a = opa; b = opb; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~opa; b = ~opb;
    n = 1;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 10);
    check({tag, "_out"}, out_w, exp);
  endtask

  initial begin
    int n, errs, ndone;
    logic signed [7:0] sa, sb;
    int prod;
    logic [15:0] exp;

    tick(); tick();
    rst = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_out", out_w, 0);

    // Detailed timing of the first operation: 5 * 3
    a = 8'd5; b = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    errs = 0;
    for (int k = 1; k <= 9; k++) begin
      if (busy !== 1'b1 || done !== 1'b0) errs++;
      if (k < 9) tick();
    end
    check("first_busy_window", errs, 0);
    tick();
    check("first_done", done, 1);
    check("first_busy_drop", busy, 0);
    check("first_out", out_w, 16'h000F);
    tick();
    check("first_done_pulse", done, 0);
    check("first_out_held", out_w, 16'h000F);

    do_op(8'hFD, 8'd5,  16'hFFF1, "neg3x5");
    do_op(8'd0,  8'hF9, 16'h0000, "zeroxneg7");
    do_op(8'h80, 8'h80, 16'h4000, "m128xm128");
    do_op(8'h7F, 8'h80, 16'hC080, "127xm128");
    do_op(8'hFF, 8'hFF, 16'h0001, "m1xm1");

    // start re-pulsed and operands changed during RUN: 6 * 7 only
    a = 8'd6; b = 8'd7; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int k = 2; k <= 25; k++) begin
      if (k >= 3 && k <= 6) begin
        start = 1'b1; a = 8'hFB; b = 8'd9;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) ndone++;
    end
    check("ignore_done_count", ndone, 1);
    check("ignore_out", out_w, 16'h002A);

    // reset on edge 5 of an operation
    a = 8'd9; b = 8'd9; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_out", out_w, 0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_out_still0", out_w, 0);
    do_op(8'd9, 8'd9, 16'h0051, "after_abort");

    // start held high: one result every 10 cycles
    a = 8'd2; b = 8'd3; start = 1'b1;
    errs = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done !== ((k % 10) == 0)) errs++;
      if (busy !== ((k % 10) != 0)) errs++;
    end
    start = 1'b0;
    check("stream_pattern", errs, 0);
    check("stream_out", out_w, 16'h0006);
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check("stream_drain", busy, 0);

    for (int i = 0; i < 1000; i++) begin
      sa = 8'($urandom);
      sb = 8'($urandom);
      prod = int'(sa) * int'(sb);
      exp = prod[15:0];
      do_op(sa, sb, exp, "random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
